// File: rtl/uart_transceiver_8n1_if.sv
// Host-side bundle of the 8N1 transceiver: serial lines, baud divisor and byte handshakes.
// The device (transceiver) uses the slave modport; the host or bench uses master.
interface uart_transceiver_8n1_if;
    logic        uart_rx;
    logic        uart_tx;
    logic [15:0] divisor;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_break;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_done;

    modport slave (
        input  uart_rx, divisor, tx_data, tx_wr,
        output uart_tx, rx_data, rx_done, rx_break, tx_done
    );

    modport master (
        output uart_rx, divisor, tx_data, tx_wr,
        input  uart_tx, rx_data, rx_done, rx_break, tx_done
    );
endinterface

// File: rtl/uart_transceiver_8n1.sv
// Full-duplex 8N1 UART with a shared 16x tick generator, 2-FF RX synchroniser,
// mid-bit RX sampling and an independent TX serialiser; all outputs are registered.
module uart_transceiver_8n1 (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    uart_transceiver_8n1_if.slave  bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [15:0] reload_s;
    logic        tick_s;
    logic [15:0] tick_cnt_q;

    logic        rx_meta_q;
    logic        rxs_q;

    logic [0:0]  rx_state_q, rx_state_d;
    logic [3:0]  rx_cnt16_q, rx_cnt16_d;
    logic [3:0]  rx_bitcnt_q, rx_bitcnt_d;
    logic [7:0]  rx_shreg_q, rx_shreg_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_done_q, rx_done_d;
    logic        rx_break_q, rx_break_d;

    logic [0:0]  tx_state_q, tx_state_d;
    logic [3:0]  tx_cnt16_q, tx_cnt16_d;
    logic [3:0]  tx_bitcnt_q, tx_bitcnt_d;
    logic [7:0]  tx_shreg_q, tx_shreg_d;
    logic        uart_tx_q, uart_tx_d;
    logic        tx_done_q, tx_done_d;

    // Divisors 0 and 1 both collapse to a reload of 0, i.e. a tick every clock.
    assign reload_s = (bus.divisor <= 16'd1) ? 16'd0 : (bus.divisor - 16'd1);
    assign tick_s   = (tick_cnt_q == 16'd0);

    // 16x tick down-counter
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tick_cnt_q <= reload_s;
        end else if (tick_s) begin
            tick_cnt_q <= reload_s;
        end else begin
            tick_cnt_q <= tick_cnt_q - 16'd1;
        end
    end

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= bus.uart_rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // RX next-state: start at cnt16=7 so the first wrap lands mid start bit
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt16_d  = rx_cnt16_q;
        rx_bitcnt_d = rx_bitcnt_q;
        rx_shreg_d  = rx_shreg_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        rx_break_d  = 1'b0;
        if (tick_s) begin
            case (rx_state_q)
                ST_IDLE: begin
                    if (!rxs_q) begin
                        rx_state_d  = ST_BUSY;
                        rx_cnt16_d  = 4'd7;
                        rx_bitcnt_d = 4'd0;
                    end else begin
                        rx_state_d  = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    rx_cnt16_d = rx_cnt16_q + 4'd1;
                    if (rx_cnt16_q == 4'd15) begin
                        if (rx_bitcnt_q == 4'd0) begin
                            if (rxs_q) begin
                                rx_state_d  = ST_IDLE;
                            end else begin
                                rx_bitcnt_d = 4'd1;
                            end
                        end else if (rx_bitcnt_q <= 4'd8) begin
                            rx_shreg_d  = {rxs_q, rx_shreg_q[7:1]};
                            rx_bitcnt_d = rx_bitcnt_q + 4'd1;
                        end else begin
                            rx_state_d = ST_IDLE;
                            if (rxs_q) begin
                                rx_data_d = rx_shreg_q;
                                rx_done_d = 1'b1;
                            end else if (rx_shreg_q == 8'd0) begin
                                rx_break_d = 1'b1;
                            end else begin
                                rx_break_d = 1'b0;
                            end
                        end
                    end else begin
                        rx_bitcnt_d = rx_bitcnt_q;
                    end
                end
                default: begin
                    rx_state_d = ST_IDLE;
                end
            endcase
        end else begin
            rx_state_d = rx_state_q;
        end
    end

    // RX state registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_state_q  <= ST_IDLE;
            rx_cnt16_q  <= 4'd0;
            rx_bitcnt_q <= 4'd0;
            rx_shreg_q  <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_done_q   <= 1'b0;
            rx_break_q  <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt16_q  <= rx_cnt16_d;
            rx_bitcnt_q <= rx_bitcnt_d;
            rx_shreg_q  <= rx_shreg_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            rx_break_q  <= rx_break_d;
        end
    end

    // TX next-state: a write while busy is simply not looked at
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt16_d  = tx_cnt16_q;
        tx_bitcnt_d = tx_bitcnt_q;
        tx_shreg_d  = tx_shreg_q;
        uart_tx_d   = uart_tx_q;
        tx_done_d   = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (bus.tx_wr) begin
                    tx_state_d  = ST_BUSY;
                    tx_shreg_d  = bus.tx_data;
                    uart_tx_d   = 1'b0;
                    tx_cnt16_d  = 4'd1;
                    tx_bitcnt_d = 4'd0;
                end else begin
                    uart_tx_d   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (tick_s) begin
                    tx_cnt16_d = tx_cnt16_q + 4'd1;
                    if (tx_cnt16_q == 4'd15) begin
                        tx_bitcnt_d = tx_bitcnt_q + 4'd1;
                        if (tx_bitcnt_q <= 4'd7) begin
                            uart_tx_d  = tx_shreg_q[0];
                            tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
                        end else if (tx_bitcnt_q == 4'd8) begin
                            uart_tx_d = 1'b1;
                        end else begin
                            uart_tx_d  = 1'b1;
                            tx_state_d = ST_IDLE;
                            tx_done_d  = 1'b1;
                        end
                    end else begin
                        tx_bitcnt_d = tx_bitcnt_q;
                    end
                end else begin
                    tx_cnt16_d = tx_cnt16_q;
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                uart_tx_d  = 1'b1;
            end
        endcase
    end

    // TX state registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx_state_q  <= ST_IDLE;
            tx_cnt16_q  <= 4'd0;
            tx_bitcnt_q <= 4'd0;
            tx_shreg_q  <= 8'd0;
            uart_tx_q   <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt16_q  <= tx_cnt16_d;
            tx_bitcnt_q <= tx_bitcnt_d;
            tx_shreg_q  <= tx_shreg_d;
            uart_tx_q   <= uart_tx_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign bus.uart_tx  = uart_tx_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_done  = rx_done_q;
    assign bus.rx_break = rx_break_q;
    assign bus.tx_done  = tx_done_q;
endmodule

// File: tb/tb_uart_transceiver_8n1.sv
// Directed bench for uart_transceiver_8n1 at divisor=4 (64 clocks per bit):
// a table of loopback frames plus hand-written reset, break, glitch and busy-write sequences.
module tb_uart_transceiver_8n1;
    logic clk;
    logic rst;
    logic rx_drive;
    logic loop_en;

    uart_transceiver_8n1_if bus ();

    uart_transceiver_8n1 dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus.slave)
    );

    assign bus.uart_rx = loop_en ? bus.uart_tx : rx_drive;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_rx_done  = 0;
    int n_rx_break = 0;
    int n_tx_done  = 0;

    // Frame bit i is the i-th bit on the wire: {stop, data[7:0], start}
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];

    // Pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.rx_done === 1'b1)  n_rx_done++;
        if (bus.rx_break === 1'b1) n_rx_break++;
        if (bus.tx_done === 1'b1)  n_tx_done++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_capture(input logic [7:0] d, input logic inject, output logic [9:0] fr);
        int t;
        bus.tx_data = d;
        bus.tx_wr   = 1'b1;
        @(negedge clk);
        bus.tx_wr   = 1'b0;
        bus.tx_data = 8'h00;
        t = 0;
        while (bus.uart_tx !== 1'b0 && t < 8) begin
            @(negedge clk);
            t++;
        end
        check("start_bit_seen", {31'd0, (t < 8)}, 32'd1);
        repeat (30) @(negedge clk);
        fr[0] = bus.uart_tx;
        for (int i = 1; i < 10; i++) begin
            if (inject && i == 3) begin
                bus.tx_data = 8'hFF;
                bus.tx_wr   = 1'b1;
                @(negedge clk);
                bus.tx_wr   = 1'b0;
                bus.tx_data = 8'h00;
                repeat (63) @(negedge clk);
            end else begin
                repeat (64) @(negedge clk);
            end
            fr[i] = bus.uart_tx;
        end
    endtask

    task automatic wait_tx_done(input int max_cyc);
        int t;
        t = 0;
        while (bus.tx_done !== 1'b1 && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        check("tx_done_in_time", {31'd0, (t < max_cyc)}, 32'd1);
    endtask

    task automatic drive_rx(input logic [9:0] fr);
        for (int i = 0; i < 10; i++) begin
            rx_drive = fr[i];
            repeat (64) @(negedge clk);
        end
        rx_drive = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fr;
        int s_rx, s_brk, s_tx;

        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h3C, 10'h278};
        vecs[2] = '{8'h00, 10'h200};
        vecs[3] = '{8'hFF, 10'h3FE};
        vecs[4] = '{8'h81, 10'h302};

        rst         = 1'b1;
        rx_drive    = 1'b1;
        loop_en     = 1'b0;
        bus.divisor = 16'd4;
        bus.tx_data = 8'h00;
        bus.tx_wr   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_uart_tx", {31'd0, bus.uart_tx}, 32'd1);
        check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check("rst_strobes", {29'd0, bus.rx_done, bus.rx_break, bus.tx_done}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_uart_tx", {31'd0, bus.uart_tx}, 32'd1);
        check("post_rst_pulses", n_rx_done + n_rx_break + n_tx_done, 32'd0);

        // Reset in the middle of a frame of 0x00
        bus.tx_data = 8'h00;
        bus.tx_wr   = 1'b1;
        @(negedge clk);
        bus.tx_wr   = 1'b0;
        repeat (200) @(negedge clk);
        check("midframe_tx_low", {31'd0, bus.uart_tx}, 32'd0);
        s_tx = n_tx_done;
        #2 rst = 1'b1;
        #1 check("midframe_rst_tx_high", {31'd0, bus.uart_tx}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (800) @(negedge clk);
        check("midframe_no_tx_done", n_tx_done - s_tx, 32'd0);
        check("midframe_idle_high", {31'd0, bus.uart_tx}, 32'd1);

        // Loopback table
        loop_en = 1'b1;
        repeat (10) @(negedge clk);
        for (int v = 0; v < 5; v++) begin
            s_rx = n_rx_done; s_brk = n_rx_break; s_tx = n_tx_done;
            send_capture(vecs[v].data, 1'b0, fr);
            check($sformatf("frame_%0h", vecs[v].data), {22'd0, fr}, {22'd0, vecs[v].frame});
            wait_tx_done(300);
            repeat (10) @(negedge clk);
            check($sformatf("rx_data_%0h", vecs[v].data), {24'd0, bus.rx_data}, {24'd0, vecs[v].data});
            check($sformatf("rx_done_cnt_%0h", vecs[v].data), n_rx_done - s_rx, 32'd1);
            check($sformatf("tx_done_cnt_%0h", vecs[v].data), n_tx_done - s_tx, 32'd1);
            check($sformatf("no_break_%0h", vecs[v].data), n_rx_break - s_brk, 32'd0);
        end

        // Break: ten zero bit times, then idle
        loop_en = 1'b0;
        rx_drive = 1'b1;
        repeat (50) @(negedge clk);
        s_rx = n_rx_done; s_brk = n_rx_break;
        rx_drive = 1'b0;
        repeat (640) @(negedge clk);
        rx_drive = 1'b1;
        repeat (300) @(negedge clk);
        check("break_pulse_cnt", n_rx_break - s_brk, 32'd1);
        check("break_no_rx_done", n_rx_done - s_rx, 32'd0);
        check("break_rx_data_held", {24'd0, bus.rx_data}, 32'h81);

        // Two-tick low glitch, then a valid 0x00 frame
        s_rx = n_rx_done; s_brk = n_rx_break;
        rx_drive = 1'b0;
        repeat (8) @(negedge clk);
        rx_drive = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_rx_done", n_rx_done - s_rx, 32'd0);
        check("glitch_no_break", n_rx_break - s_brk, 32'd0);
        drive_rx(10'h200);
        repeat (100) @(negedge clk);
        check("after_glitch_rx_done", n_rx_done - s_rx, 32'd1);
        check("after_glitch_rx_data", {24'd0, bus.rx_data}, 32'h00);

        // Write of 0xFF while 0x5A is in flight must be ignored
        loop_en = 1'b1;
        repeat (20) @(negedge clk);
        s_rx = n_rx_done; s_tx = n_tx_done;
        send_capture(8'h5A, 1'b1, fr);
        check("busy_frame_5a", {22'd0, fr}, 32'h2B4);
        wait_tx_done(300);
        repeat (800) @(negedge clk);
        check("busy_tx_done_cnt", n_tx_done - s_tx, 32'd1);
        check("busy_rx_done_cnt", n_rx_done - s_rx, 32'd1);
        check("busy_rx_data", {24'd0, bus.rx_data}, 32'h5A);
        check("busy_line_idle", {31'd0, bus.uart_tx}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
